// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester valid/ready arbiter in front of a shared combinational ALU
// Build option: ALU_ARB_FIXED_PRIO_EN gives req0 fixed priority instead of round-robin.
module alu_arbiter #(
  parameter int WIDTH      = 19,
  parameter int MULDIV_LAT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_carry,
  output logic             rsp_overflow,
  output logic [1:0]       rsp_err,
  output logic [WIDTH-1:0] alu_r2,
  output logic [WIDTH-1:0] alu_r3,
  output logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] alu_r1,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow
);

  localparam int CW = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, HOLD, RESP} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             id_q;
  logic             capture;
  logic             grant, pick1;
  logic             op_legal, is_muldiv, div0, op_ok, alu_active;
  logic [WIDTH-1:0] cap_result;
  logic [1:0]       cap_err;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign pick1 = req1_valid && !req0_valid;
`else
  logic last_grant;
  assign pick1 = req1_valid && (!req0_valid || !last_grant);
`endif

  // Reset is folded in so ready stays low while rst_n is asserted.
  assign grant      = (state == IDLE) && rst_n && (req0_valid || req1_valid);
  assign req0_ready = grant && !pick1;
  assign req1_ready = grant && pick1;

  always_comb begin
    op_legal = 1'b0;
    case (op_q)
      4'b0000, 4'b0001, 4'b0010, 4'b0011,
      4'b0110, 4'b0111, 4'b1000, 4'b1001: op_legal = 1'b1;
      default:                            op_legal = 1'b0;
    endcase
  end

  assign is_muldiv  = (op_q == 4'b0010) || (op_q == 4'b0011);
  assign div0       = (op_q == 4'b0011) && (b_q == '0);
  assign op_ok      = op_legal && !div0;
  assign alu_active = ((state == EXEC) || (state == HOLD)) && op_ok;

  assign alu_op = alu_active ? op_q : 4'b1111;
  assign alu_r2 = alu_active ? a_q  : '0;
  assign alu_r3 = alu_active ? b_q  : '0;

  always_comb begin
    cap_result = alu_r1;
    cap_err    = 2'b00;
    if (!op_legal) begin
      cap_result = '0;
      cap_err    = 2'b10;
    end else if (div0) begin
      cap_result = '1;
      cap_err    = 2'b01;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: if (grant) state_nx = EXEC;
      EXEC: begin
        if (op_ok && is_muldiv && (MULDIV_LAT > 1)) begin
          cnt_nx   = CW'(MULDIV_LAT - 1);
          state_nx = HOLD;
        end else begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      HOLD: begin
        cnt_nx = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          capture  = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      id_q         <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_zero     <= 1'b0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_err      <= 2'b00;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (grant) begin
        op_q <= pick1 ? req1_op : req0_op;
        a_q  <= pick1 ? req1_a  : req0_a;
        b_q  <= pick1 ? req1_b  : req0_b;
        id_q <= pick1;
`ifndef ALU_ARB_FIXED_PRIO_EN
        last_grant <= pick1;
`endif
      end
      if (capture) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= id_q;
        rsp_result   <= cap_result;
        rsp_zero     <= op_ok && alu_zero;
        rsp_carry    <= op_ok && alu_carry;
        rsp_overflow <= op_ok && alu_overflow;
        rsp_err      <= cap_err;
      end else if ((state == RESP) && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
